keypad_scanner: RTL and testbench

Column-drive side of the 4x4 Pmod keypad interface: sequentially drives one column low, samples the active-low rows, and debounces the whole-matrix result. Emits a decoded 4-bit hex key code with a one-cycle valid strobe per debounced press. Sits between the keypad header (col on JA[3:0], row on JA[7:4]) and the player-input logic. Runs on the 100 MHz system clock.

---
 rtl/keypad_scanner.sv | 126 ++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Column-scanning driver for a 4x4 active-low keypad with whole-matrix debounce.
// Emits a one-cycle strobe and hex code for each debounced key press.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_sw,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi
);

  localparam int SetW = $clog2(SETTLE_CYCLES);
  localparam int CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] DbMax      = CntW'(DEBOUNCE_SCANS);
  // Nibble i holds the hex code of sample bit i = column*4 + row.
  localparam logic [63:0] KeyMap = 64'hDCBA_E963_F852_0741;

  typedef enum logic {
    DRIVE,
    EVAL
  } scanState_t;

  scanState_t state, nextState;

  logic [3:0]      rowMeta, rowSync;
  logic [SetW-1:0] settleCnt;
  logic [1:0]      colIdx;
  logic [15:0]     samples;
  logic [15:0]     lowBits;
  logic            scanFound;
  logic [3:0]      scanCode;
  logic            scanMulti;
  logic [4:0]      scanResult;
  logic [4:0]      lastResult;
  logic [CntW-1:0] stableCnt;
  logic            sameResult;
  logic            accept;

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) state <= DRIVE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    col       = 4'b1111;
    case (state)
      DRIVE: begin
        col[colIdx] = 1'b0;
        if (settleCnt == SettleLast && colIdx == 2'd3) nextState = EVAL;
      end
      EVAL:    nextState = DRIVE;
      default: nextState = DRIVE;
    endcase
  end

  // Lowest sample index wins, giving leftmost column then top row priority.
  always_comb begin
    scanFound = 1'b0;
    scanCode  = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (!samples[i]) begin
        scanFound = 1'b1;
        scanCode  = KeyMap[i*4 +: 4];
      end
    end
    lowBits    = ~samples;
    scanMulti  = |(lowBits & (lowBits - 16'd1));
    scanResult = {scanFound, scanCode};
    sameResult = (scanResult == lastResult);
    accept     = sameResult ? (stableCnt == DbMax - CntW'(1)) : (DEBOUNCE_SCANS == 1);
  end

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      rowMeta    <= 4'hF;
      rowSync    <= 4'hF;
      settleCnt  <= '0;
      colIdx     <= 2'd0;
      samples    <= '1;
      lastResult <= 5'd0;
      stableCnt  <= '0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi      <= 1'b0;
    end else begin
      rowMeta   <= row;
      rowSync   <= rowMeta;
      key_valid <= 1'b0;
      if (state == DRIVE) begin
        if (settleCnt == SettleLast) begin
          settleCnt                   <= '0;
          samples[{colIdx, 2'b00} +: 4] <= rowSync;
          colIdx                      <= colIdx + 2'd1;
        end else begin
          settleCnt <= settleCnt + SetW'(1);
        end
      end else begin
        multi <= scanMulti;
        if (sameResult) begin
          if (stableCnt != DbMax) stableCnt <= stableCnt + CntW'(1);
        end else begin
          lastResult <= scanResult;
          stableCnt  <= CntW'(1);
        end
        if (accept) begin
          if (scanFound) begin
            key_code  <= scanCode;
            key_held  <= 1'b1;
            key_valid <= 1'b1;
          end else begin
            key_held <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-level reference model of the keypad scanner with a strobe scoreboard;
// a simple matrix model pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

  localparam int SETTLE = 8;
  localparam int DB     = 2;
  localparam int PERIOD = 4 * SETTLE + 1;

  logic       clk = 1'b0;
  logic       reset_sw = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi;
  logic [15:0] pressMask = 16'h0000;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } strobe_t;

  strobe_t sbQueue[$];

  logic [3:0] keyAt [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                               '{4'h2, 4'h5, 4'h8, 4'hF},
                               '{4'h3, 4'h6, 4'h9, 4'hE},
                               '{4'hA, 4'hB, 4'hC, 4'hD}};

  int         cyc = 0;
  int         scanIdx = 0;
  int         passCount = 0;
  int         checkCount = 0;
  logic [4:0] mdlLast = 5'd0;
  int         mdlCnt = 0;
  logic       mdlHeld = 1'b0;
  logic       mdlMulti = 1'b0;
  logic [3:0] mdlCode = 4'h0;

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressMask[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset_sw(reset_sw), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi(multi)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d, scan %0d)",
                  tag, observed, expected, cyc, scanIdx);
  endtask

  function automatic logic [15:0] keyMask(input logic [3:0] code);
    logic [15:0] m = 16'h0000;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keyAt[c][r] == code) m[c*4+r] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] expectedResult(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[c*4+r]) return {1'b1, keyAt[c][r]};
    return 5'd0;
  endfunction

  task automatic modelScan(input logic [15:0] m);
    logic [4:0] res;
    logic       acc;
    strobe_t    s;
    res      = expectedResult(m);
    acc      = 1'b0;
    mdlMulti = ($countones(m) >= 2);
    if (res == mdlLast) begin
      if (mdlCnt < DB) begin
        mdlCnt++;
        acc = (mdlCnt == DB);
      end
    end else begin
      mdlLast = res;
      mdlCnt  = 1;
      acc     = (DB == 1);
    end
    if (acc) begin
      if (res[4]) begin
        mdlCode = res[3:0];
        mdlHeld = 1'b1;
        s.cyc   = PERIOD * (scanIdx + 1);
        s.code  = res[3:0];
        sbQueue.push_back(s);
      end else begin
        mdlHeld = 1'b0;
      end
    end
  endtask

  task automatic resetModel();
    mdlLast  = 5'd0;
    mdlCnt   = 0;
    mdlHeld  = 1'b0;
    mdlMulti = 1'b0;
    mdlCode  = 4'h0;
  endtask

  task automatic stepCycle();
    int         phase;
    logic [3:0] expCol;
    phase  = cyc % PERIOD;
    expCol = 4'b1111;
    if (phase < 4 * SETTLE) expCol[phase / SETTLE] = 1'b0;
    checkOutput("col", col, expCol);
    if (sbQueue.size() > 0 && sbQueue[0].cyc == cyc) begin
      checkOutput("keyValid", key_valid, 1);
      checkOutput("keyCodeStrobe", key_code, sbQueue[0].code);
      void'(sbQueue.pop_front());
    end else begin
      checkOutput("keyValidIdle", key_valid, 0);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic startScan(input logic [15:0] m);
    checkOutput("keyHeld", key_held, mdlHeld);
    checkOutput("multi", multi, mdlMulti);
    checkOutput("keyCode", key_code, mdlCode);
    pressMask = m;
    modelScan(m);
    scanIdx++;
  endtask

  task automatic applyStimulus(input logic [15:0] m, input int nScans);
    repeat (nScans) begin
      startScan(m);
      repeat (PERIOD) stepCycle();
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Col"}, col, 4'b1110);
    checkOutput({tag, "Code"}, key_code, 0);
    checkOutput({tag, "Valid"}, key_valid, 0);
    checkOutput({tag, "Held"}, key_held, 0);
    checkOutput({tag, "Multi"}, multi, 0);
  endtask

  task automatic midScanReset(input logic [15:0] m, input int cyclesIn);
    startScan(m);
    repeat (cyclesIn) stepCycle();
    reset_sw = 1'b1;
    #1;
    checkResetState("midReset");
    checkOutput("sbFlushed", 8'(sbQueue.size()), 0);
    sbQueue.delete();
    resetModel();
    @(negedge clk);
    @(negedge clk);
    reset_sw = 1'b0;
    cyc      = 0;
    scanIdx  = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset_sw = 1'b0;

    applyStimulus(16'h0000, 3);
    applyStimulus(keyMask(4'h5), 11);
    applyStimulus(16'h0000, 3);
    applyStimulus(keyMask(4'h9), 1);
    applyStimulus(16'h0000, 3);
    applyStimulus(keyMask(4'h1) | keyMask(4'hD), 3);
    applyStimulus(16'h0000, 3);
    applyStimulus(keyMask(4'hE), 3);
    midScanReset(keyMask(4'hE), 18);
    applyStimulus(keyMask(4'hE), 3);
    applyStimulus(keyMask(4'hB), 3);
    applyStimulus(16'h0000, 3);

    checkOutput("finalHeld", key_held, mdlHeld);
    checkOutput("finalCode", key_code, mdlCode);
    checkOutput("sbEmpty", 8'(sbQueue.size()), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
